// File: rtl/rs_issue_scheduler_if.sv
//==============================================================================
// rs_issue_scheduler_if : decode/RS/FU signal bundle for rs_issue_scheduler
// Rev 1.0
//==============================================================================
`default_nettype none

interface rs_issue_scheduler_if #(
  parameter int NUM_RS     = 4,
  parameter int ROBsizeLog = 4
);
  logic                         dispatch_valid_i;
  logic                         dispatch_ready_o;
  logic [NUM_RS-1:0]            rs_write_en_o;
  logic [NUM_RS-1:0]            rs_busy_i;
  logic [NUM_RS-1:0]            rs_ready_i;
  logic [NUM_RS*64-1:0]         rs_val1_i;
  logic [NUM_RS*64-1:0]         rs_val2_i;
  logic [NUM_RS*10-1:0]         rs_commands_i;
  logic [NUM_RS*ROBsizeLog-1:0] rs_tag_i;
  logic [NUM_RS-1:0]            rs_stall_o;
  logic                         fu_valid_o;
  logic                         fu_ready_i;
  logic [63:0]                  fu_val1_o;
  logic [63:0]                  fu_val2_o;
  logic [9:0]                   fu_commands_o;
  logic [ROBsizeLog-1:0]        fu_tag_o;

  modport master (
    input  dispatch_valid_i, rs_busy_i, rs_ready_i, rs_val1_i, rs_val2_i,
           rs_commands_i, rs_tag_i, fu_ready_i,
    output dispatch_ready_o, rs_write_en_o, rs_stall_o, fu_valid_o,
           fu_val1_o, fu_val2_o, fu_commands_o, fu_tag_o
  );

  modport slave (
    output dispatch_valid_i, rs_busy_i, rs_ready_i, rs_val1_i, rs_val2_i,
           rs_commands_i, rs_tag_i, fu_ready_i,
    input  dispatch_ready_o, rs_write_en_o, rs_stall_o, fu_valid_o,
           fu_val1_o, fu_val2_o, fu_commands_o, fu_tag_o
  );
endinterface

`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
//==============================================================================
// rs_issue_scheduler : steers dispatch into free RSs, round-robin issue to one FU
// Rev 1.0
//==============================================================================
`default_nettype none

module rs_issue_scheduler #(
  parameter int NUM_RS     = 4,
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  wire logic            clk_i,
  input  wire logic            reset_i,
  rs_issue_scheduler_if.master bus
);

  localparam int               PTR_W    = $clog2(NUM_RS);
  localparam logic [PTR_W:0]   NUM_RS_W = (PTR_W + 1)'(NUM_RS);

  logic [NUM_RS-1:0]     free;
  logic [NUM_RS-1:0]     low_free;
  logic                  found_free;
  logic [NUM_RS-1:0]     req;
  logic                  out_free;
  logic                  fire;
  logic [2*NUM_RS-1:0]   req_masked;
  logic                  found_req;
  logic [PTR_W:0]        first_pos;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_RS-1:0]     grant;
  logic [PTR_W:0]        ptr_inc;

  logic [63:0]           sel_val1;
  logic [63:0]           sel_val2;
  logic [9:0]            sel_cmd;
  logic [ROBsizeLog-1:0] sel_tag;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  fu_valid_q, fu_valid_d;
  logic [63:0]           val1_q, val1_d;
  logic [63:0]           val2_q, val2_d;
  logic [9:0]            cmd_q, cmd_d;
  logic [ROBsizeLog-1:0] tag_q, tag_d;

  // Dispatch: lowest-index free RS gets the write enable.
  always_comb begin
    free       = ~bus.rs_busy_i;
    low_free   = '0;
    found_free = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!found_free && free[i]) begin
        low_free[i] = 1'b1;
        found_free  = 1'b1;
      end
    end
  end

  assign bus.dispatch_ready_o = |free;
  assign bus.rs_write_en_o    = (reset_i && bus.dispatch_valid_i) ? low_free : '0;

  assign req      = bus.rs_ready_i & bus.rs_busy_i;
  assign out_free = ~fu_valid_q | bus.fu_ready_i;
  assign fire     = (|req) & out_free;

  // Round-robin search: duplicate req and mask off positions below rr_ptr,
  // so the first set bit is the next requester at or after the pointer.
  assign req_masked = {req, req} & ({(2*NUM_RS){1'b1}} << rr_ptr_q);

  always_comb begin
    found_req = 1'b0;
    first_pos = '0;
    for (int j = 0; j < 2*NUM_RS; j++) begin
      if (!found_req && req_masked[j]) begin
        found_req = 1'b1;
        first_pos = (PTR_W + 1)'(j);
      end
    end
    if (first_pos >= NUM_RS_W) begin
      first_pos = first_pos - NUM_RS_W;
    end
    grant_idx = first_pos[PTR_W-1:0];
    grant     = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      grant[i] = found_req && (grant_idx == PTR_W'(i));
    end
    ptr_inc = {1'b0, grant_idx} + (PTR_W + 1)'(1);
    if (ptr_inc >= NUM_RS_W) begin
      ptr_inc = '0;
    end
  end

  always_comb begin
    sel_val1 = '0;
    sel_val2 = '0;
    sel_cmd  = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (grant[i]) begin
        sel_val1 = bus.rs_val1_i[i*64 +: 64];
        sel_val2 = bus.rs_val2_i[i*64 +: 64];
        sel_cmd  = bus.rs_commands_i[i*10 +: 10];
        sel_tag  = bus.rs_tag_i[i*ROBsizeLog +: ROBsizeLog];
      end
    end
  end

  assign bus.rs_stall_o = reset_i ? ~({NUM_RS{fire}} & grant) : '1;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    fu_valid_d = fu_valid_q;
    val1_d     = val1_q;
    val2_d     = val2_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    if (fire) begin
      fu_valid_d = 1'b1;
      val1_d     = sel_val1;
      val2_d     = sel_val2;
      cmd_d      = sel_cmd;
      tag_d      = sel_tag;
      rr_ptr_d   = ptr_inc[PTR_W-1:0];
    end else if (bus.fu_ready_i) begin
      fu_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rr_ptr_q   <= '0;
      fu_valid_q <= 1'b0;
      val1_q     <= '0;
      val2_q     <= '0;
      cmd_q      <= '0;
      tag_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      fu_valid_q <= fu_valid_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
    end
  end

  assign bus.fu_valid_o    = fu_valid_q;
  assign bus.fu_val1_o     = val1_q;
  assign bus.fu_val2_o     = val2_q;
  assign bus.fu_commands_o = cmd_q;
  assign bus.fu_tag_o      = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
//==============================================================================
// tb_rs_issue_scheduler : scoreboard bench with directed and random stimulus
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_rs_issue_scheduler;
  localparam int N  = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rs_issue_scheduler_if #(.NUM_RS(N), .ROBsizeLog(TW)) bus();

  rs_issue_scheduler #(.NUM_RS(N), .ROBsize(8)) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [63:0]   v1;
    logic [63:0]   v2;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_valid;
  int    m_rr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_rs(input int i, input logic [63:0] v1, input logic [63:0] v2,
                        input logic [9:0] c, input logic [TW-1:0] t);
    bus.rs_val1_i[i*64 +: 64]     = v1;
    bus.rs_val2_i[i*64 +: 64]     = v2;
    bus.rs_commands_i[i*10 +: 10] = c;
    bus.rs_tag_i[i*TW +: TW]      = t;
  endtask

  // Reference model: evaluated once per cycle with the inputs settled.
  task automatic model_step();
    logic [N-1:0] exp_we;
    logic [N-1:0] exp_stall;
    int           g;
    item_t        it;
    chk("dispatch_ready", bus.dispatch_ready_o, (bus.rs_busy_i != {N{1'b1}}));
    if (!reset_n) begin
      chk("reset_stall", bus.rs_stall_o, {N{1'b1}});
      chk("reset_we", bus.rs_write_en_o, '0);
      sb.delete();
      m_valid = 1'b0;
      m_rr    = 0;
      return;
    end
    exp_we = '0;
    if (bus.dispatch_valid_i) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.rs_busy_i[i]) begin
          exp_we[i] = 1'b1;
          break;
        end
      end
    end
    chk("write_en", bus.rs_write_en_o, exp_we);
    chk("fu_valid", bus.fu_valid_o, m_valid);
    g = -1;
    if (!m_valid || bus.fu_ready_i) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (bus.rs_busy_i[idx] && bus.rs_ready_i[idx]) begin
          g = idx;
          break;
        end
      end
    end
    exp_stall = '1;
    if (g >= 0) exp_stall[g] = 1'b0;
    chk("stall", bus.rs_stall_o, exp_stall);
    if (g >= 0) begin
      it.v1  = bus.rs_val1_i[g*64 +: 64];
      it.v2  = bus.rs_val2_i[g*64 +: 64];
      it.cmd = bus.rs_commands_i[g*10 +: 10];
      it.tag = bus.rs_tag_i[g*TW +: TW];
      sb.push_back(it);
      m_valid = 1'b1;
      m_rr    = (g + 1) % N;
    end else if (bus.fu_ready_i) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: compare the presented output against the oldest expected issue.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.fu_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got valid output expected none at %0t", $time);
      end else begin
        chk("mon_val1", bus.fu_val1_o, sb[0].v1);
        chk("mon_val2", bus.fu_val2_o, sb[0].v2);
        chk("mon_cmd",  bus.fu_commands_o, sb[0].cmd);
        chk("mon_tag",  bus.fu_tag_o, sb[0].tag);
        if (bus.fu_ready_i) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]  fill_busy [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
  logic [N-1:0]  fill_we   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [TW-1:0] rr_tags   [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
  logic [63:0]   held_v1;
  logic [TW-1:0] held_tag;

  initial begin
    reset_n              = 1'b0;
    bus.dispatch_valid_i = 1'b0;
    bus.rs_busy_i        = '0;
    bus.rs_ready_i       = '0;
    bus.fu_ready_i       = 1'b0;
    bus.rs_val1_i        = '0;
    bus.rs_val2_i        = '0;
    bus.rs_commands_i    = '0;
    bus.rs_tag_i         = '0;
    for (int i = 0; i < N; i++)
      set_rs(i, 64'h100 + 64'(i), 64'h200 + 64'(i), 10'(i + 5), TW'(i + 1));
    @(posedge clk);
    #1;

    // Reset with every RS ready, then round-robin starting at RS0.
    bus.rs_busy_i  = '1;
    bus.rs_ready_i = '1;
    bus.fu_ready_i = 1'b1;
    #1 chk("rst_stall_peek", bus.rs_stall_o, 4'b1111);
    step();
    step();
    chk("rst_fu_valid", bus.fu_valid_o, 0);
    chk("rst_fu_val1", bus.fu_val1_o, 0);
    chk("rst_fu_cmd", bus.fu_commands_o, 0);
    chk("rst_fu_tag", bus.fu_tag_o, 0);
    reset_n = 1'b1;
    #1 chk("first_grant_rs0", bus.rs_stall_o, 4'b1110);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_tag", bus.fu_tag_o, rr_tags[k]);
      chk("rr_valid", bus.fu_valid_o, 1);
    end

    // Dispatch fill.
    bus.rs_ready_i       = '0;
    bus.dispatch_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.rs_busy_i = fill_busy[k];
      #1 chk("fill_we", bus.rs_write_en_o, fill_we[k]);
      step();
    end
    chk("fill_full_ready", bus.dispatch_ready_o, 0);
    bus.dispatch_valid_i = 1'b0;

    // Backpressure with RS2 waiting.
    bus.rs_ready_i = 4'b0001;
    step();
    bus.fu_ready_i = 1'b0;
    bus.rs_ready_i = 4'b0100;
    set_rs(2, 64'hA, 64'hB, 10'h2A, 4'd3);
    held_v1  = bus.fu_val1_o;
    held_tag = bus.fu_tag_o;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_stall", bus.rs_stall_o, 4'b1111);
      step();
      chk("bp_hold_val1", bus.fu_val1_o, held_v1);
      chk("bp_hold_tag", bus.fu_tag_o, held_tag);
    end
    bus.fu_ready_i = 1'b1;
    #1 chk("bp_release_stall", bus.rs_stall_o, 4'b1011);
    step();
    chk("bp_val1", bus.fu_val1_o, 64'hA);
    chk("bp_tag", bus.fu_tag_o, 4'd3);

    // Forwarded operand captured in the ready cycle.
    bus.rs_ready_i = 4'b0010;
    set_rs(1, 64'hDEAD, 64'h1, 10'h11, 4'd2);
    #1 chk("fwd_stall", bus.rs_stall_o, 4'b1101);
    step();
    chk("fwd_val1", bus.fu_val1_o, 64'hDEAD);
    bus.rs_ready_i = '0;
    #1 chk("fwd_stall_after", bus.rs_stall_o, 4'b1111);
    step();

    // Simultaneous dispatch and issue, then mid-operation reset.
    bus.rs_busy_i        = 4'b0111;
    bus.rs_ready_i       = 4'b0001;
    bus.dispatch_valid_i = 1'b1;
    #1 chk("sim_we", bus.rs_write_en_o, 4'b1000);
    chk("sim_stall", bus.rs_stall_o, 4'b1110);
    step();
    reset_n = 1'b0;
    step();
    chk("midrst_valid", bus.fu_valid_o, 0);
    reset_n              = 1'b1;
    bus.dispatch_valid_i = 1'b0;
    bus.rs_busy_i        = '1;
    bus.rs_ready_i       = '1;
    #1 chk("midrst_ptr0", bus.rs_stall_o, 4'b1110);
    step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      reset_n              = ($urandom_range(0, 199) != 0);
      bus.dispatch_valid_i = 1'($urandom_range(0, 1));
      bus.rs_busy_i        = N'($urandom);
      bus.rs_ready_i       = N'($urandom);
      bus.fu_ready_i       = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        set_rs(i, {$urandom, $urandom}, {$urandom, $urandom}, 10'($urandom), TW'($urandom));
      step();
    end

    // Drain.
    reset_n        = 1'b1;
    bus.rs_busy_i  = '0;
    bus.rs_ready_i = '0;
    bus.fu_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("sb_empty", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
